// File: rtl/bcd_tally_display_if.sv
// Increment strobe and the two active-low seven-segment digit buses of the tally display.
// The master modport is the side that drives inc; the slave modport is the display block.
interface bcd_tally_display_if;
  logic       inc;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  modport master (output inc, input HEX0, input HEX1);
  modport slave  (input inc, output HEX0, output HEX1);
endinterface

// File: rtl/bcd_tally_display.sv
// Two-digit BCD tally 00..99 on active-low seven-segment digits; one cycle from an inc sample to the new count.
// Always accepts inc, with no backpressure; the display reads 00 while Empty and idle.
module bcd_tally_display (
  input  logic                 Clock,
  input  logic                 Reset,
  bcd_tally_display_if.slave   tally
);

  typedef enum logic {EMPTY = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;

  // Values 9..15 all fold to 0, so a corrupted digit recovers on the next increment.
  function automatic logic [3:0] inc_digit(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= EMPTY;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    case (state_q)
      EMPTY:   if (tally.inc) state_d = COUNT;
      COUNT:   state_d = COUNT;
      default: state_d = EMPTY;
    endcase
    if (tally.inc) begin
      ones_d = inc_digit(ones_q);
      if (ones_d == 4'd0) tens_d = inc_digit(tens_q);
    end
  end

  always_comb begin
    tally.HEX0 = seg_decode(ones_q);
    tally.HEX1 = seg_decode(tens_q);
    if (state_q == EMPTY && !tally.inc) begin
      tally.HEX0 = SEG_ZERO;
      tally.HEX1 = SEG_ZERO;
    end
  end

endmodule

// File: tb/tb_bcd_tally_display.sv
// Directed bench for bcd_tally_display: drives on the falling edge, checks after each rising edge.
module tb_bcd_tally_display;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_tally_display_if tally_if ();

  bcd_tally_display dut (
    .Clock (clk),
    .Reset (rst),
    .tally (tally_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] exp_disp(input int n);
    return {seg_tab[(n % 100) / 10], seg_tab[n % 10]};
  endfunction

  // One rising edge, then land on the falling edge for checking and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tally_if.inc = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [13:0] disp();
    return {tally_if.HEX1, tally_if.HEX0};
  endfunction

  initial begin
    rst = 1'b1;
    tally_if.inc = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_disp", disp(), exp_disp(0));
    check("reset_fsm", 14'(dut.state_q), 14'd0);
    tick();
    tick();
    check("idle_disp", disp(), exp_disp(0));
    check("idle_fsm", 14'(dut.state_q), 14'd0);

    // Empty with inc high shows the decoded 00 before the edge.
    tally_if.inc = 1'b1;
    #1;
    check("empty_inc_disp", disp(), exp_disp(0));
    tick();
    tally_if.inc = 1'b0;
    check("pulse_01", disp(), exp_disp(1));
    check("pulse_fsm", 14'(dut.state_q), 14'd1);
    tick();
    tick();
    check("hold_01", disp(), exp_disp(1));

    do_reset();
    for (int i = 1; i <= 10; i++) begin
      tally_if.inc = 1'b1;
      tick();
      check($sformatf("run10_%0d", i), disp(), exp_disp(i));
    end
    check("carry_10", disp(), {7'b1111001, 7'b1000000});

    do_reset();
    tally_if.inc = 1'b1;
    for (int i = 1; i <= 24; i++) tick();
    tally_if.inc = 1'b0;
    check("run24", disp(), {7'b0100100, 7'b0011001});
    tick();
    tick();
    check("hold24", disp(), {7'b0100100, 7'b0011001});

    do_reset();
    tally_if.inc = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (i == 99) check("reach_99", disp(), {7'b0010000, 7'b0010000});
      if (i % 7 == 0) check($sformatf("run100_%0d", i), disp(), exp_disp(i));
    end
    tally_if.inc = 1'b0;
    check("wrap_00", disp(), exp_disp(0));
    check("wrap_fsm", 14'(dut.state_q), 14'd1);

    do_reset();
    tally_if.inc = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    check("at_08", disp(), exp_disp(8));
    rst = 1'b1;
    tick();
    check("rst_prio_disp", disp(), exp_disp(0));
    check("rst_prio_fsm", 14'(dut.state_q), 14'd0);
    rst = 1'b0;
    tick();
    tally_if.inc = 1'b0;
    check("after_rst_01", disp(), exp_disp(1));
    check("after_rst_fsm", 14'(dut.state_q), 14'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_tally_display.md
Name: bcd_tally_display

Overview:
- Two-digit decimal (BCD) event counter, 00..99, incremented by a single-cycle `inc` strobe.
- Drives two active-low seven-segment displays. HEX1 shows the tens digit; HEX0 shows the ones digit.
- Used as a score/tally display in the game top level.
- Internally composed of three parts:
  - a per-digit BCD incrementer (9 wraps to 0);
  - a per-digit seven-segment decoder;
  - a two-state Empty/Count FSM.

Parameters:
- None. Digit count, display polarity and segment encoding are fixed.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high. Clears the count to 00 and the FSM to Empty.
- inc  input  1  increment request, sampled on each rising edge. Held high means +1 per cycle.
- HEX0  output  7  ones-digit segments, active-low, bit order [6:0] = g,f,e,d,c,b,a.
- HEX1  output  7  tens-digit segments, same encoding as HEX0.

Behaviour:
- State:
  - ones[3:0] and tens[3:0] hold BCD values.
  - FSM state is Empty or Count.
- Reset (synchronous, active-high):
  - On a rising edge with Reset=1: ones=0, tens=0, FSM=Empty.
  - Reset has priority over inc.
  - Reset asserted mid-count takes effect on that edge.
- Increment, on a rising edge with Reset=0 and inc=1:
  - ones <= inc_digit(ones).
  - If inc_digit(ones)==0 (carry out), tens <= inc_digit(tens); otherwise tens holds.
- inc=0 and Reset=0: count holds.
- inc_digit function:
  - 0..8 maps to value+1.
  - 9 maps to 0.
  - Non-BCD inputs 10..15 map to 0.
- Wrap-around:
  - 99 plus one inc gives 00.
  - The FSM stays in Count after a wrap.
  - There is no saturation and no overflow flag.
- Latency: one cycle from the inc sample to the new count. HEX outputs are combinational from the registered count and FSM state; no further delay.
- FSM:
  - Empty: stays Empty while inc=0; goes to Count when inc=1.
  - Count: stays in Count until Reset.
- Outputs:
  - In Empty with inc=0, both HEX outputs are forced to the "0" pattern (7'b1000000).
  - In all other cases, HEX1=decode(tens) and HEX0=decode(ones).
  - Since the count is 00 in Empty, the display always reads 00 after reset.
- Decoder, active-low patterns for g..a:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - 10..15 give 1111111 (blank).
- Power-up: state is undefined until the first Reset edge. The integrating design must assert Reset before use.
- The block is fully synchronous: no latches and no asynchronous paths from inputs to state. The outputs depend combinationally on inc only through the Empty-state display mux.

Test Plan:
- Reset=1 for 1 cycle, then inc=0 for 2 cycles -> HEX1=HEX0=1000000 (00), state Empty.
- After reset, one inc pulse -> count 01 (HEX1=1000000, HEX0=1111001) from the next edge onward. It holds at 01 with inc=0.
- inc held high 10 cycles from 00 -> the count passes 01..09, then reads 10 on the 10th edge (HEX1=1111001, HEX0=1000000), confirming the ones-to-tens carry.
- inc held high 24 cycles from 00 -> 24 (HEX1=0100100, HEX0=0011001). Then inc=0 for 2 cycles -> it stays 24.
- inc held high 100 cycles from 00 -> reaches 99 (HEX1=HEX0=0010000) after 99 edges, then 00 on the 100th edge. The FSM stays in Count.
- Count at 08 with Reset=1 and inc=1 on the same edge -> count 00 and Empty. Releasing Reset with inc=1 -> 01 on the following edge.
